// File: rtl/gray_decoder.sv
// Gray-code receive decoder: registers Gray samples, converts them to binary, and tracks +1 step lock.
// Optional build macro GRAY_DEC_REPEAT_EN tolerates repeated codes in LOCKING/LOCKED.
module gray_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic             G_CLK_RX,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic             sync_ok,
  output logic [7:0]       err_count
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  g_q;
  logic              v_q;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [CntW-1:0]   good_q, good_d;
  logic [7:0]        err_cnt_d;
  logic              step_err_d;
  logic              sync_d;
  logic [WIDTH-1:0]  cur_bin;
  logic [WIDTH-1:0]  step;
  logic              step_one;
  logic              repeat_ok;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign cur_bin  = g2b(g_q);
  assign step     = cur_bin - prev_q;
  assign step_one = (step == WIDTH'(1));

`ifdef GRAY_DEC_REPEAT_EN
  assign repeat_ok = (step == '0);
`else
  assign repeat_ok = 1'b0;
`endif

  // State register, input stage and registered outputs.
  always_ff @(posedge G_CLK_RX or negedge rst) begin
    if (!rst) begin
      g_q       <= '0;
      v_q       <= 1'b0;
      state_q   <= StUnlocked;
      prev_q    <= '0;
      good_q    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      sync_ok   <= 1'b0;
      err_count <= '0;
    end else begin
      if (gray_valid) begin
        g_q <= gray_in;
      end
      v_q       <= gray_valid;
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      if (v_q) begin
        bin_out <= cur_bin;
      end
      bin_valid <= v_q;
      step_err  <= step_err_d;
      sync_ok   <= sync_d;
      err_count <= err_cnt_d;
    end
  end

  // Next-state logic: only accepted samples (v_q) move the tracker.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    err_cnt_d  = err_count;
    step_err_d = 1'b0;
    if (v_q) begin
      prev_d = cur_bin;
      unique case (state_q)
        StUnlocked: begin
          good_d  = '0;
          state_d = StLocking;
        end
        StLocking: begin
          if (step_one) begin
            good_d = good_q + CntW'(1);
            if (good_d == CntW'(LOCK_COUNT)) begin
              state_d = StLocked;
            end
          end else if (!repeat_ok) begin
            good_d = '0;
          end
        end
        StLocked: begin
          if (!step_one && !repeat_ok) begin
            step_err_d = 1'b1;
            if (err_count != 8'hFF) begin
              err_cnt_d = err_count + 8'd1;
            end
            good_d  = '0;
            state_d = StLocking;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
  end

  // sync_ok is registered so it moves on the same edge as the state.
  always_comb begin
    sync_d = (state_d == StLocked);
  end

endmodule
